// File: rtl/mips_pkg.sv
// Shared MIPS definitions: branch compare select bit positions and the
// 2-bit bimodal predictor counter encodings.
package mips_pkg;

  // Bit positions inside ex_op, ordered like MIPS_DECINFO_BJP_*.
  localparam int unsigned BJP_GEZ  = 0;
  localparam int unsigned BJP_LTZ  = 1;
  localparam int unsigned BJP_EQ   = 2;
  localparam int unsigned BJP_NE   = 3;
  localparam int unsigned BJP_LEZ  = 4;
  localparam int unsigned BJP_GTZ  = 5;
  localparam int unsigned BJP_OP_W = 6;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_cnt_e;

  localparam bht_cnt_e BHT_RESET = WNT;

  // Saturating step of a 2-bit direction counter.
  function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
    bht_cnt_e nxt;
    nxt = cur;
    unique case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = BHT_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mips_bjp_bht.sv
// Bimodal branch history table: asynchronous read, synchronous saturating
// update, asynchronous reset of every entry to weakly not-taken.
module mips_bjp_bht
  import mips_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_cnt_e   cnt_q [BHT_DEPTH];
  logic [1:0] rd_cnt;

  assign rd_cnt   = cnt_q[rd_idx];
  assign rd_taken = rd_cnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        cnt_q[i] <= BHT_RESET;
      end
    end else if (wr_en) begin
      cnt_q[wr_idx] <= bht_next(cnt_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/mips_ex_bjp_unit.sv
// EX-stage branch resolution: compares, target, mispredict flush/redirect,
// statistics. BHT is built only when MIPS_BJP_BHT_EN is defined.
module mips_ex_bjp_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic                ex_stall,
  input  logic [BJP_OP_W-1:0] ex_op,
  input  logic [DATA_W-1:0]   ex_rs,
  input  logic [DATA_W-1:0]   ex_rt,
  input  logic [DATA_W-1:0]   ex_imm,
  input  logic [ADDR_W-1:0]   ex_pc_incr,
  input  logic                ex_pred_taken,
  input  logic [ADDR_W-1:0]   if_lookup_pc_incr,
  output logic                if_pred_taken,
  output logic                bjp_flush,
  output logic [ADDR_W-1:0]   bjp_redirect_pc,
  output logic [CNT_W-1:0]    bjp_branch_cnt,
  output logic [CNT_W-1:0]    bjp_mispred_cnt
);

  logic                rs_neg;
  logic                rs_zero;
  logic                rs_eq_rt;
  logic [BJP_OP_W-1:0] cmp;
  logic                op_onehot;
  logic                taken;
  logic [DATA_W-1:0]   offset;
  logic [ADDR_W-1:0]   target;
  logic [ADDR_W-1:0]   next_pc;
  logic                resolve;
  logic                mispred;
  logic                unused_bits;

  // Sign bit and zero detect replace a subtractor for the signed tests.
  assign rs_neg   = ex_rs[DATA_W-1];
  assign rs_zero  = (ex_rs == '0);
  assign rs_eq_rt = (ex_rs == ex_rt);

  always_comb begin
    cmp          = '0;
    cmp[BJP_GEZ] = ~rs_neg;
    cmp[BJP_LTZ] = rs_neg;
    cmp[BJP_EQ]  = rs_eq_rt;
    cmp[BJP_NE]  = ~rs_eq_rt;
    cmp[BJP_LEZ] = rs_neg | rs_zero;
    cmp[BJP_GTZ] = ~rs_neg & ~rs_zero;
  end

  assign op_onehot = (ex_op != '0) && ((ex_op & (ex_op - 1'b1)) == '0);
  assign taken     = op_onehot & (|(ex_op & cmp));

  assign offset  = ex_imm << 2;
  assign target  = ex_pc_incr + offset[ADDR_W-1:0];
  assign next_pc = taken ? target : ex_pc_incr;

  assign resolve = ex_valid & ~ex_stall & ~bjp_flush;
  assign mispred = taken ^ ex_pred_taken;

  assign unused_bits = ^{if_lookup_pc_incr, ex_pc_incr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bjp_flush       <= 1'b0;
      bjp_redirect_pc <= '0;
      bjp_branch_cnt  <= '0;
      bjp_mispred_cnt <= '0;
    end else if (!ex_stall) begin
      bjp_flush <= resolve & mispred;
      if (resolve) begin
        bjp_redirect_pc <= next_pc;
        if (bjp_branch_cnt != '1) begin
          bjp_branch_cnt <= bjp_branch_cnt + 1'b1;
        end
        if (mispred && (bjp_mispred_cnt != '1)) begin
          bjp_mispred_cnt <= bjp_mispred_cnt + 1'b1;
        end
      end
    end
  end

`ifdef MIPS_BJP_BHT_EN
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  mips_bjp_bht #(
    .BHT_DEPTH(BHT_DEPTH)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_lookup_pc_incr[IDX_W+1:2]),
    .rd_taken (if_pred_taken),
    .wr_en    (resolve),
    .wr_idx   (ex_pc_incr[IDX_W+1:2]),
    .wr_taken (taken)
  );
`else
  assign if_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_mips_ex_bjp_unit.sv
// Scoreboard bench for mips_ex_bjp_unit: directed scenarios then random
// traffic, checked against a behavioural model of the branch rules.
module tb_mips_ex_bjp_unit;

  localparam int unsigned DEPTH = 16;
`ifdef MIPS_BJP_BHT_EN
  localparam bit BHT_EN = 1'b1;
`else
  localparam bit BHT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_stall = 1'b0;
  logic [5:0]  ex_op = '0;
  logic [31:0] ex_rs = '0;
  logic [31:0] ex_rt = '0;
  logic [31:0] ex_imm = '0;
  logic [31:0] ex_pc_incr = '0;
  logic        ex_pred_taken = 1'b0;
  logic [31:0] if_lookup_pc_incr = '0;

  logic        pred_a, pred_b;
  logic        flush_a, flush_b;
  logic [31:0] redir_a, redir_b;
  logic [15:0] bcnt_a, mcnt_a;
  logic [3:0]  bcnt_b, mcnt_b;

  mips_ex_bjp_unit #(.DATA_W(32), .ADDR_W(32), .BHT_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_op(ex_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_pc_incr(ex_pc_incr),
    .ex_pred_taken(ex_pred_taken), .if_lookup_pc_incr(if_lookup_pc_incr),
    .if_pred_taken(pred_a), .bjp_flush(flush_a), .bjp_redirect_pc(redir_a),
    .bjp_branch_cnt(bcnt_a), .bjp_mispred_cnt(mcnt_a)
  );

  mips_ex_bjp_unit #(.DATA_W(32), .ADDR_W(32), .BHT_DEPTH(DEPTH), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_op(ex_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_pc_incr(ex_pc_incr),
    .ex_pred_taken(ex_pred_taken), .if_lookup_pc_incr(if_lookup_pc_incr),
    .if_pred_taken(pred_b), .bjp_flush(flush_b), .bjp_redirect_pc(redir_b),
    .bjp_branch_cnt(bcnt_b), .bjp_mispred_cnt(mcnt_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          pred;
    bit          flush;
    bit [31:0]   redir;
    int unsigned b16, m16, b4, m4;
  } exp_t;

  exp_t q[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference state
  bit          m_flush;
  bit [31:0]   m_redir;
  int unsigned m_b16, m_m16, m_b4, m_m4;
  int          m_bht [DEPTH];

  localparam bit [5:0] OP_GEZ = 6'b000001, OP_LTZ = 6'b000010, OP_EQ = 6'b000100,
                       OP_NE = 6'b001000, OP_LEZ = 6'b010000, OP_GTZ = 6'b100000;

  function automatic int bidx(input bit [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit ref_taken(input bit [5:0] op, input bit [31:0] rs, input bit [31:0] rt);
    int s;
    bit [5:0] r;
    s = rs;
    if ($countones(op) != 1) return 1'b0;
    r = {s > 0, s <= 0, rs != rt, rs == rt, s < 0, s >= 0};
    return (op & r) != 6'b0;
  endfunction

  function automatic bit ref_pred(input bit [31:0] pc);
    return BHT_EN && (m_bht[bidx(pc)] >= 2);
  endfunction

  task automatic model_reset();
    m_flush = 0; m_redir = 0; m_b16 = 0; m_m16 = 0; m_b4 = 0; m_m4 = 0;
    for (int i = 0; i < int'(DEPTH); i++) m_bht[i] = 1;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.tag = tag; e.pred = ref_pred(if_lookup_pc_incr); e.flush = m_flush; e.redir = m_redir;
    e.b16 = m_b16; e.m16 = m_m16; e.b4 = m_b4; e.m4 = m_m4;
    q.push_back(e);
  endtask

  task automatic step(input bit v, input bit st, input bit [5:0] op, input bit [31:0] rs,
                      input bit [31:0] rt, input bit [31:0] imm, input bit [31:0] pc,
                      input bit pr, input bit [31:0] lk, input string tag);
    bit tk, mis;
    int k;
    @(posedge clk); #1;
    rst = 1'b0;
    ex_valid = v; ex_stall = st; ex_op = op; ex_rs = rs; ex_rt = rt; ex_imm = imm;
    ex_pc_incr = pc; ex_pred_taken = pr; if_lookup_pc_incr = lk;
    push_exp(tag);
    if (!st) begin
      if (v && !m_flush) begin
        tk  = ref_taken(op, rs, rt);
        mis = (tk != pr);
        m_redir = tk ? pc + imm * 4 : pc;
        m_flush = mis;
        if (m_b16 < 65535) m_b16++;
        if (m_b4 < 15) m_b4++;
        if (mis && m_m16 < 65535) m_m16++;
        if (mis && m_m4 < 15) m_m4++;
        k = bidx(pc);
        if (tk) m_bht[k] = (m_bht[k] == 3) ? 3 : m_bht[k] + 1;
        else    m_bht[k] = (m_bht[k] == 0) ? 0 : m_bht[k] - 1;
      end else begin
        m_flush = 0;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 1'b0; ex_stall = 1'b0;
    model_reset();
    push_exp(tag);
  endtask

  task automatic idle(input bit [31:0] lk, input string tag);
    step(0, 0, OP_EQ, 0, 0, 0, 32'h100, 0, lk, tag);
  endtask

  task automatic chk(input string tag, input string n, input longint unsigned act,
                     input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s/%s act=%0h exp=%0h", tag, n, act, exp);
    end
  endtask

  // Monitor: registered outputs and the combinational lookup are stable mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.tag, "pred_a", pred_a, e.pred);
        chk(e.tag, "pred_b", pred_b, e.pred);
        chk(e.tag, "flush_a", flush_a, e.flush);
        chk(e.tag, "flush_b", flush_b, e.flush);
        chk(e.tag, "redir", redir_a, e.redir);
        chk(e.tag, "bcnt16", bcnt_a, e.b16);
        chk(e.tag, "mcnt16", mcnt_a, e.m16);
        chk(e.tag, "bcnt4", bcnt_b, e.b4);
        chk(e.tag, "mcnt4", mcnt_b, e.m4);
        chk(e.tag, "redir4", redir_b, e.redir);
      end
    end
  end

  function automatic bit [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit [5:0]  op;
    bit [31:0] rs, rt, imm, pc, lk;
    bit        pr;
    int        k;

    model_reset();
    do_reset("por");
    idle(32'h104, "por_idle");

    step(1, 0, OP_EQ, 5, 5, 32'h10, 32'h100, 0, 32'h100, "beq");
    step(1, 0, OP_NE, 1, 2, 32'h40, 32'h300, 0, 32'h300, "shadow");
    idle(32'h300, "beq_after");
    idle(32'h300, "flush_clear");

    step(1, 0, OP_LTZ, 32'h8000_0000, 0, 32'hFFFF_FFFC, 32'h200, 1, 32'h200, "bltz");
    idle(32'h200, "bltz_after");

    step(1, 0, OP_EQ, 1, 1, 0, 32'h104, 1, 32'h104, "train_t1");
    step(1, 0, OP_EQ, 1, 1, 0, 32'h104, 1, 32'h104, "train_t2");
    idle(32'h104, "train_hi");
    for (int i = 0; i < 3; i++) step(1, 0, OP_NE, 7, 7, 0, 32'h104, 0, 32'h104, "train_nt");
    idle(32'h104, "train_lo");

    step(1, 1, OP_EQ, 5, 5, 32'h10, 32'h108, 0, 32'h108, "stall_v");
    idle(32'h108, "stall_after");
    step(1, 0, OP_EQ, 5, 5, 32'h8, 32'h108, 0, 32'h108, "mis_then_stall");
    step(1, 1, OP_EQ, 5, 5, 32'h8, 32'h108, 0, 32'h108, "stall_hold");
    step(1, 0, OP_EQ, 5, 5, 32'h8, 32'h108, 0, 32'h108, "shadow2");
    idle(32'h108, "shadow2_after");

    for (int i = 0; i < 40; i++) step(1, 0, OP_EQ, 3, 3, 32'h4, 32'h180, 0, 32'h180, "sat");
    idle(32'h180, "sat_end");

    step(1, 0, OP_GTZ, 9, 0, 32'h20, 32'h1F0, 0, 32'h1F0, "pre_rst");
    do_reset("mid_rst");
    idle(32'h180, "post_rst");
    idle(32'h104, "post_rst2");

    for (int n = 0; n < 500; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 8) op = 6'b1 << $urandom_range(0, 5);
      else if (k == 8) op = 6'b0;
      else op = 6'($urandom);
      rs = pick();
      rt = ($urandom_range(0, 1) != 0) ? rs : pick();
      if ($urandom_range(0, 1) != 0) imm = 32'(int'($urandom_range(0, 64)) - 32);
      else imm = $urandom;
      pc = 32'h100 + ($urandom_range(0, 63) << 2);
      lk = ($urandom_range(0, 3) == 0) ? pc : 32'h100 + ($urandom_range(0, 63) << 2);
      pr = ($urandom_range(0, 1) != 0) ? ref_pred(pc) : 1'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, op, rs, rt, imm, pc, pr, lk, "rand");
    end

    repeat (2) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain act=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_ex_bjp_unit.md
# mips_ex_bjp_unit

Parametrised branch resolution unit for the EX stage. Evaluates the six MIPS conditional-branch compares on forwarded operands and computes the branch target. Compares the outcome against the IF-stage prediction and raises a registered redirect/flush on mispredict. Also owns a bimodal branch history table (BHT) with 2-bit saturating counters, read by IF and trained by EX.

## Interface
Parameters:
- `DATA_W`, 32, operand width (rs, rt, imm).
- `ADDR_W`, 32, PC width; must be ≤ `DATA_W`.
- `BHT_DEPTH`, 64, number of BHT entries; power of two, ≥ 2.
- `CNT_W`, 16, width of each statistics counter.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: branch instruction present in EX this cycle.
- `ex_stall` in 1: pipeline stall. While high, inputs are ignored and all state holds.
- `ex_op` in 6: one-hot compare select, bits {gtz, lez, ne, eq, ltz, gez} [5:0]. Zero or multi-hot means never taken.
- `ex_rs`, `ex_rt` in `DATA_W`: forwarded operands (signed).
- `ex_imm` in `DATA_W`: sign-extended branch offset, in words.
- `ex_pc_incr` in `ADDR_W`: PC+4 of the branch.
- `ex_pred_taken` in 1: direction predicted in IF.
- `if_lookup_pc_incr` in `ADDR_W`: PC+4 being fetched.
- `if_pred_taken` out 1: BHT prediction for the lookup PC (combinational).
- `bjp_flush` out 1: registered mispredict; kill IF/ID.
- `bjp_redirect_pc` out `ADDR_W`: registered correct next PC, valid when `bjp_flush` is high.
- `bjp_branch_cnt` out `CNT_W`: resolved branches.
- `bjp_mispred_cnt` out `CNT_W`: mispredicted branches.

## Operation
- Compare results:
  - gez: `rs ≥ 0`
  - ltz: `rs < 0`
  - eq: `rs == rt`
  - ne: `rs != rt`
  - lez: `rs ≤ 0`
  - gtz: `rs > 0`
- Signed tests use `rs[DATA_W-1]` and a zero test only; no subtractor is used.
- `taken` is the OR of the selected compare results. `taken` is 0 for a zero or multi-hot `ex_op`.
- Target is `ex_pc_incr + (ex_imm << 2)`, truncated to `ADDR_W` with wrap-around (no overflow detection).
- Next PC is the target if `taken`, otherwise `ex_pc_incr`.
- A resolve happens when `ex_valid & ~ex_stall & ~bjp_flush`. The instruction in EX during a flush cycle is wrong-path and is dropped.
- On a resolve:
  - `bjp_flush` is registered as `taken ^ ex_pred_taken`.
  - `bjp_redirect_pc` is registered as the next PC.
  - `bjp_branch_cnt` increments by 1.
  - `bjp_mispred_cnt` increments by 1 on mismatch.
  - Both counters saturate at all-ones.
  - The BHT entry is trained: increment on taken, saturating at 3; decrement on not-taken, saturating at 0.
- In any cycle that is not a resolve, `bjp_flush` clears to 0 and `bjp_redirect_pc` holds.
- Exception: while `ex_stall` is high, `bjp_flush` also holds its current value.
- BHT index is `pc_incr[IDX_W+1:2]`, where `IDX_W = log2(BHT_DEPTH)`.
- Prediction is the counter's MSB.

## Timing
- `if_pred_taken` is combinational from `if_lookup_pc_incr`.
- BHT write takes effect at the clock edge of the resolve cycle. A same-cycle lookup at the same index returns the old value (read-before-write).
- Flush latency: 1 cycle. A resolve in cycle N gives `bjp_flush` high in cycle N+1, for exactly one cycle unless stalled.
- Back-to-back resolves are allowed in consecutive cycles only when the first does not flush.
- Values on reset:
  - `bjp_flush` = 0
  - `bjp_redirect_pc` = 0
  - both counters = 0
  - all BHT entries = 2'b01 (weakly not-taken)
- Reset asserted mid-operation aborts any pending flush immediately (asynchronous).
- Simultaneous `ex_stall` and `ex_valid`: no resolve, no training, no counting.

## Configuration
- `MIPS_BJP_BHT_EN` defined:
  - BHT storage and training are built.
  - `if_pred_taken` behaves as above.
- `MIPS_BJP_BHT_EN` undefined:
  - No BHT storage.
  - `if_pred_taken` is tied to 0 (static not-taken).
  - Training logic is removed.
  - Compare, flush, redirect and statistics behaviour are unchanged.

## Structure
- Shared `mips_pkg`:
  - `ex_op` bit positions (BGEZ..BGTZ), matching the existing `MIPS_DECINFO_BJP_*` ordering.
  - 2-bit counter encodings: `SNT`=0, `WNT`=1, `WT`=2, `ST`=3.
  - BHT reset value.
- One sub-module, `mips_bjp_bht`:
  - parameter `BHT_DEPTH`
  - asynchronous read port
  - synchronous saturating update port
  - asynchronous reset of all entries

## Test plan
- Reset: assert `rst` mid-run. All outputs go to 0 and all BHT entries read `if_pred_taken`=0. Both counters read 0.
- BEQ mispredict: `rs`=5, `rt`=5, `imm`=0x10, `pc_incr`=0x100, pred 0. Next cycle: `bjp_flush`=1, `redirect`=0x140, `mispred_cnt`=1. One cycle later: `bjp_flush`=0.
- BLTZ correct, backward target: `rs`=0x80000000, `imm`=0xFFFFFFFC, `pc_incr`=0x200, pred 1. Result: no flush, `branch_cnt` +1. Internal target evaluates to 0x1F0.
- BHT training: resolve taken twice at `pc_incr`=0x104. `if_lookup_pc_incr`=0x104 reads 0 during the first resolve cycle (read-before-write) and 1 after. Three not-taken resolves return it to 0.
- Stall and shadow: (a) `ex_valid`=1 with `ex_stall`=1 produces no state change. (b) A valid branch presented in the cycle `bjp_flush`=1 is dropped: `branch_cnt` unchanged, BHT unchanged.
- Saturation: with `CNT_W`=4, 20 mispredicted resolves leave both counters at 15. With `MIPS_BJP_BHT_EN` undefined, `if_pred_taken` stays 0 throughout.
